// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: receiver FSM encoding, parity modes and baud divider helper.
// Revision 1.0
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per oversample tick, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int den;
    int q;
    den = baud * os;
    q   = (clk_freq + den / 2) / den;
    return (q < 1) ? 1 : q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// uart_sync_fifo: single-clock show-ahead FIFO, head reads as zero when empty.
// Revision 1.0
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// uart_rx_fifo: oversampling UART receiver feeding a show-ahead receive FIFO.
// Revision 1.0
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          I_sys_clk,
  input  logic                          I_rst,
  input  logic                          I_enable,
  input  logic                          I_rx_serial_data,
  input  logic                          I_rx_ready,
  output logic [DATA_BITS-1:0]          O_rx_data,
  output logic                          O_rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   O_fifo_count,
  output logic                          O_frame_err,
  output logic                          O_parity_err,
  output logic                          O_overrun,
  output logic                          O_break
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 push_q, push_d;
  logic [DATA_BITS-1:0] push_data_q, push_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 break_q, break_d;
  logic                 overrun_q, overrun_d;

  logic tick, fall, sample_half, sample_full;
  logic exp_par, frame_bad, par_bad;
  logic fifo_full, fifo_empty, pop;

  assign tick        = (div_q == DIV_LAST);
  assign fall        = prev_q && !sync2_q;
  assign sample_half = tick && (tick_cnt_q == TICK_HALF);
  assign sample_full = tick && (tick_cnt_q == TICK_LAST);
  assign exp_par     = (PARITY == PAR_ODD) ? ~^shift_q : ^shift_q;
  assign frame_bad   = stop_bad_q || !sync2_q;
  assign par_bad     = (PARITY != PAR_NONE) && (par_bit_q != exp_par);
  assign pop         = I_rx_ready && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? tick_cnt_q + TICK_ONE : tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    stop_bad_d   = stop_bad_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    break_d      = 1'b0;
    div_d        = tick ? '0 : div_q + DIV_ONE;

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        stop_bad_d = 1'b0;
        // Restart the prescaler so every sample lands a fixed delay after the edge.
        if (fall) begin
          state_d = ST_START;
          div_d   = '0;
        end
      end
      ST_START: begin
        if (sample_half) begin
          tick_cnt_d = '0;
          state_d    = sync2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_full) begin
          tick_cnt_d = '0;
          shift_d    = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample_full) begin
          tick_cnt_d = '0;
          par_bit_d  = sync2_q;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_full) begin
          tick_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d    = '0;
            state_d      = ST_IDLE;
            frame_err_d  = frame_bad;
            parity_err_d = par_bad;
            break_d      = frame_bad && (shift_q == '0) &&
                           ((PARITY == PAR_NONE) || !par_bit_q);
            push_d       = !frame_bad && !par_bad;
            push_data_d  = shift_q;
          end else begin
            stop_bad_d = stop_bad_q || !sync2_q;
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!I_enable) begin
      state_d      = ST_IDLE;
      div_d        = '0;
      tick_cnt_d   = '0;
      bit_cnt_d    = '0;
      push_d       = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      break_d      = 1'b0;
    end
  end

  // Overrun is flagged on the edge where the FIFO refuses the character.
  assign overrun_d = push_q && fifo_full && !pop;

  always_ff @(posedge I_sys_clk) begin
    if (!I_rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      div_q        <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_bad_q   <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= I_rx_serial_data;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      div_q        <= div_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      stop_bad_q   <= stop_bad_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      break_q      <= break_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (I_sys_clk),
    .rst_ni  (I_rst),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (pop),
    .data_o  (O_rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (O_fifo_count)
  );

  assign O_rx_valid   = !fifo_empty;
  assign O_frame_err  = frame_err_q;
  assign O_parity_err = parity_err_q;
  assign O_overrun    = overrun_q;
  assign O_break      = break_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// tb_uart_rx_fifo: scoreboard bench for an 8N1 receiver (depth 4) and an 8E1 receiver.
// Revision 1.0
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BIT_CLKS = 160;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic       rx_a  = 1'b1;
  logic       rx_b  = 1'b1;
  logic       rdy_a = 1'b0;
  logic       rdy_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;
  logic       fe_a, pe_a, ov_a, bk_a;
  logic       fe_b, pe_b, ov_b, bk_b;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_n_a = 0, pe_n_a = 0, ov_n_a = 0, bk_n_a = 0, febk_n_a = 0;
  int fe_n_b = 0, pe_n_b = 0;
  int fe0, pe0, ov0, bk0, febk0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .I_sys_clk(clk), .I_rst(rst_n), .I_enable(en), .I_rx_serial_data(rx_a),
    .I_rx_ready(rdy_a), .O_rx_data(data_a), .O_rx_valid(valid_a), .O_fifo_count(cnt_a),
    .O_frame_err(fe_a), .O_parity_err(pe_a), .O_overrun(ov_a), .O_break(bk_a)
  );

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_b (
    .I_sys_clk(clk), .I_rst(rst_n), .I_enable(en), .I_rx_serial_data(rx_b),
    .I_rx_ready(rdy_b), .O_rx_data(data_b), .O_rx_valid(valid_b), .O_fifo_count(cnt_b),
    .O_frame_err(fe_b), .O_parity_err(pe_b), .O_overrun(ov_b), .O_break(bk_b)
  );

  // Error pulses are one cycle wide, so counting on the falling edge sees each once.
  always @(negedge clk) begin
    if (fe_a) fe_n_a <= fe_n_a + 1;
    if (pe_a) pe_n_a <= pe_n_a + 1;
    if (ov_a) ov_n_a <= ov_n_a + 1;
    if (bk_a) bk_n_a <= bk_n_a + 1;
    if (fe_a && bk_a) febk_n_a <= febk_n_a + 1;
    if (fe_b) fe_n_b <= fe_n_b + 1;
    if (pe_b) pe_n_b <= pe_n_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark_a();
    fe0 = fe_n_a; pe0 = pe_n_a; ov0 = ov_n_a; bk0 = bk_n_a; febk0 = febk_n_a;
  endtask

  task automatic check_flags_a(input string tag, input int efe, input int epe,
                               input int eov, input int ebk);
    check({tag, "_frame_err"},  fe_n_a - fe0, efe);
    check({tag, "_parity_err"}, pe_n_a - pe0, epe);
    check({tag, "_overrun"},    ov_n_a - ov0, eov);
    check({tag, "_break"},      bk_n_a - bk0, ebk);
  endtask

  // With abort set, returns in the middle of data bit 3.
  task automatic send_frame_a(input logic [7:0] d, input bit abort);
    rx_a = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      if (abort && i == 3) begin
        wait_clk(BIT_CLKS / 2);
        return;
      end
      wait_clk(BIT_CLKS);
    end
    rx_a = 1'b1;
    wait_clk(BIT_CLKS);
  endtask

  task automatic send_frame_b(input logic [7:0] d, input logic p);
    rx_b = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_b = d[i];
      wait_clk(BIT_CLKS);
    end
    rx_b = p;
    wait_clk(BIT_CLKS);
    rx_b = 1'b1;
    wait_clk(BIT_CLKS);
  endtask

  task automatic pop_a(input string tag);
    int w;
    logic [7:0] exp_v;
    w = 0;
    while (!valid_a && w < 4000) begin
      wait_clk(1);
      w++;
    end
    check({tag, "_valid"}, valid_a, 1);
    exp_v = 8'hxx;
    if (q_a.size() > 0) exp_v = q_a.pop_front();
    check({tag, "_data"}, data_a, exp_v);
    rdy_a = 1'b1;
    wait_clk(1);
    rdy_a = 1'b0;
  endtask

  task automatic pop_b(input string tag);
    int w;
    logic [7:0] exp_v;
    w = 0;
    while (!valid_b && w < 4000) begin
      wait_clk(1);
      w++;
    end
    check({tag, "_valid"}, valid_b, 1);
    exp_v = 8'hxx;
    if (q_b.size() > 0) exp_v = q_b.pop_front();
    check({tag, "_data"}, data_b, exp_v);
    rdy_b = 1'b1;
    wait_clk(1);
    rdy_b = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pe0_b, fe0_b;
    logic [7:0] good_b;

    rst_n = 1'b0;
    wait_clk(5);
    check("rst_count", cnt_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_flags", {fe_a, pe_a, ov_a, bk_a}, 0);
    rst_n = 1'b1;
    wait_clk(20);

    // 8N1 reception of 0xA5
    mark_a();
    q_a.push_back(8'hA5);
    send_frame_a(8'hA5, 1'b0);
    check("a5_valid", valid_a, 1);
    check("a5_count", cnt_a, 1);
    check_flags_a("a5", 0, 0, 0, 0);
    pop_a("a5");
    check("a5_count_after_pop", cnt_a, 0);
    rdy_a = 1'b1;
    wait_clk(1);
    rdy_a = 1'b0;
    check("empty_pop_count", cnt_a, 0);
    check("empty_pop_valid", valid_a, 0);

    // Even parity: 0x03 with parity bit 1 is a mismatch
    pe0_b = pe_n_b;
    fe0_b = fe_n_b;
    send_frame_b(8'h03, 1'b1);
    wait_clk(5);
    check("perr_pulses", pe_n_b - pe0_b, 1);
    check("perr_count", cnt_b, 0);
    check("perr_frame_err", fe_n_b - fe0_b, 0);
    good_b = 8'h07;
    q_b.push_back(good_b);
    send_frame_b(good_b, ^good_b);
    pop_b("par_good");
    check("par_pulses_after_good", pe_n_b - pe0_b, 1);

    // Glitch shorter than half a bit
    mark_a();
    rx_a = 1'b0;
    wait_clk(40);
    rx_a = 1'b1;
    wait_clk(200);
    check("glitch_count", cnt_a, 0);
    check_flags_a("glitch", 0, 0, 0, 0);
    check("glitch_idle", dut_a.state_q, ST_IDLE);
    q_a.push_back(8'h5A);
    send_frame_a(8'h5A, 1'b0);
    pop_a("glitch_5a");

    // Overrun on a depth-4 FIFO
    mark_a();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q_a.push_back(8'(i));
      send_frame_a(8'(i), 1'b0);
      if (i == 4) check("ovr_none_at_4", ov_n_a - ov0, 0);
    end
    wait_clk(5);
    check("ovr_count", cnt_a, 4);
    check_flags_a("ovr", 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) pop_a("ovr_pop");
    check("ovr_empty", cnt_a, 0);

    // Break: line low for two frame times
    mark_a();
    rx_a = 1'b0;
    wait_clk(2 * 10 * BIT_CLKS);
    rx_a = 1'b1;
    wait_clk(2 * BIT_CLKS);
    check_flags_a("break", 1, 0, 0, 1);
    check("break_together", febk_n_a - febk0, 1);
    check("break_count", cnt_a, 0);
    q_a.push_back(8'h3C);
    send_frame_a(8'h3C, 1'b0);
    pop_a("break_3c");

    // Reset during data bit 3
    mark_a();
    send_frame_a(8'hC3, 1'b1);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    wait_clk(2);
    check("rstmid_count", cnt_a, 0);
    check("rstmid_valid", valid_a, 0);
    check("rstmid_data", data_a, 0);
    check("rstmid_flags", {fe_a, pe_a, ov_a, bk_a}, 0);
    check("rstmid_idle", dut_a.state_q, ST_IDLE);
    rst_n = 1'b1;
    wait_clk(12 * BIT_CLKS);
    check_flags_a("rstmid", 0, 0, 0, 0);
    check("rstmid_count_after", cnt_a, 0);
    q_a.push_back(8'hC3);
    send_frame_a(8'hC3, 1'b0);
    pop_a("rstmid_c3");

    // Disable during data bit 3; FIFO keeps a prior entry that is popped while disabled
    q_a.push_back(8'h77);
    send_frame_a(8'h77, 1'b0);
    mark_a();
    send_frame_a(8'hC3, 1'b1);
    en   = 1'b0;
    rx_a = 1'b1;
    wait_clk(2);
    check("dis_idle", dut_a.state_q, ST_IDLE);
    check("dis_tick", dut_a.tick_cnt_q, 0);
    pop_a("dis_pop");
    en = 1'b1;
    wait_clk(12 * BIT_CLKS);
    check_flags_a("dis", 0, 0, 0, 0);
    check("dis_count_after", cnt_a, 0);
    q_a.push_back(8'hC3);
    send_frame_a(8'hC3, 1'b0);
    pop_a("dis_c3");
    check("final_count", cnt_a, 0);

    wait_clk(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
